// File: rtl/uart_rx_frontend_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frontend_if
// Write-side bundle from the UART receive front end into the RX FIFO.
//   rx_done_tick : one-cycle strobe, dout valid (FIFO write enable)
//   dout         : received data word
//   frame_err    : stop bit of the last frame sampled low
//   parity_err   : parity mismatch on the last frame (0 when parity is not built)
// Modports:
//   master : driven by uart_rx_frontend
//   slave  : FIFO / observer side
// ---------------------------------------------------------------------------
interface uart_rx_frontend_if #(
    parameter int N_BIT = 8
);
    logic             rx_done_tick;
    logic [N_BIT-1:0] dout;
    logic             frame_err;
    logic             parity_err;

    modport master (output rx_done_tick, output dout, output frame_err, output parity_err);
    modport slave  (input  rx_done_tick, input  dout, input  frame_err, input  parity_err);
endinterface

// File: rtl/uart_rx_frontend.sv
// ---------------------------------------------------------------------------
// uart_rx_frontend
// Serial receive front end feeding the UART RX FIFO: two-flop synchroniser,
// free-running 16x oversampling tick, start-bit validation, 2-of-3 majority
// sampling per bit, stop-bit check and a one-cycle write strobe per frame.
//
// Ports:
//   CLK    : system clock, rising edge
//   RESET  : asynchronous active-low reset
//   rx     : raw serial line, idle high, asynchronous to CLK
//   s_tick : oversampling tick (one cycle every DVSR clocks), for the TX side
//   wr     : FIFO write bundle (rx_done_tick, dout, frame_err, parity_err)
//
// Build option: define UART_RX_PARITY_EN to insert a parity bit between the
// data bits and the stop bit (sense set by PARITY_ODD). Without it the frame
// is N_BIT+2 bits long and parity_err is held at 0.
// N_BIT must be at least 2.
// ---------------------------------------------------------------------------
module uart_rx_frontend #(
    parameter int N_BIT      = 8,
    parameter int N_TICK     = 16,
    parameter int DVSR       = 163,
    parameter int DVSR_BIT   = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 rx,
    output logic                 s_tick,
    uart_rx_frontend_if.master   wr
);
    localparam int SW = (N_TICK > 1) ? $clog2(N_TICK) : 1;
    localparam int NW = (N_BIT > 1) ? $clog2(N_BIT) : 1;

    localparam logic [SW-1:0]       S_LAST = SW'(N_TICK - 1);
    localparam logic [SW-1:0]       S_MID  = SW'(N_TICK / 2 - 1);
    localparam logic [SW-1:0]       S_SMP0 = SW'(N_TICK - 3);
    localparam logic [SW-1:0]       S_SMP1 = SW'(N_TICK - 2);
    localparam logic [NW-1:0]       N_LAST = NW'(N_BIT - 1);
    localparam logic [DVSR_BIT-1:0] B_LAST = DVSR_BIT'(DVSR - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

    // synchroniser
    logic rx_meta_q, rx_s_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // baud generator: free-running, independent of the FSM
    logic [DVSR_BIT-1:0] baud_q, baud_d;
    logic                tick;

    assign tick   = (baud_q == B_LAST);
    assign baud_d = tick ? '0 : baud_q + 1'b1;
    assign s_tick = tick;

    // receiver state
    state_t           state_q, state_d;
    logic [SW-1:0]    s_q, s_d;
    logic [NW-1:0]    n_q, n_d;
    logic [N_BIT-1:0] sh_q, sh_d;
    logic [1:0]       smp_q, smp_d;
    logic [N_BIT-1:0] dout_q, dout_d;
    logic             done_q, done_d;
    logic             fe_q, fe_d;
    logic             maj;

    // The third sample is the live rx_s on the consuming tick, so the vote
    // needs only the two earlier samples stored.
    assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic pe_q, pe_d;
`else
    // parity sense only matters when the parity state is built in
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        sh_d    = sh_q;
        smp_d   = smp_q;
        dout_d  = dout_q;
        fe_d    = fe_q;
        done_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        pe_d    = pe_q;
`endif

        if (tick && (state_q == DATA || state_q == PARITY || state_q == STOP)) begin
            if (s_q == S_SMP0) smp_d[0] = rx_s_q;
            if (s_q == S_SMP1) smp_d[1] = rx_s_q;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        // line must still be low mid start bit, else glitch
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d  = '0;
                        sh_d = {maj, sh_q[N_BIT-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        par_d   = maj;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d    = '0;
                        dout_d = sh_q;
                        done_d = 1'b1;
                        fe_d   = ~maj;
`ifdef UART_RX_PARITY_EN
                        pe_d   = (^sh_q) ^ par_q ^ PARITY_ODD;
`endif
                        // a low stop bit may be a break: wait for the line to
                        // go idle before hunting for the next start edge
                        state_d = maj ? IDLE : BREAK_WAIT;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            BREAK_WAIT: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            baud_q  <= '0;
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            sh_q    <= '0;
            smp_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            baud_q  <= baud_d;
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            sh_q    <= sh_d;
            smp_q   <= smp_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            fe_q    <= fe_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            par_q <= 1'b0;
            pe_q  <= 1'b0;
        end else begin
            par_q <= par_d;
            pe_q  <= pe_d;
        end
    end
    assign wr.parity_err = pe_q;
`else
    assign wr.parity_err = 1'b0;
`endif

    assign wr.rx_done_tick = done_q;
    assign wr.dout         = dout_q;
    assign wr.frame_err    = fe_q;
endmodule
